// File: rtl/add_bit_pkg.sv
// add_bit_pkg: shared full-adder helper functions for the add_bit datapath.
package add_bit_pkg;

  // Sum bit of a 1-bit full adder.
  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  // Carry bit of a 1-bit full adder (majority of the three inputs).
  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (a & ci) | (b & ci);
  endfunction

endpackage

// File: rtl/add_bit_if.sv
// add_bit_if: operand/result bundle of the add_bit serial adder.
interface add_bit_if;
  logic in_valid;
  logic a;
  logic b;
  logic cin;
  logic chain;
  logic out;
  logic cout;
  logic out_valid;

  // Producer of operand bits, consumer of results.
  modport master (
    output in_valid, a, b, cin, chain,
    input  out, cout, out_valid
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, cin, chain,
    output out, cout, out_valid
  );
endinterface

// File: rtl/add_bit_core.sv
// add_bit_core: purely combinational 1-bit full adder, reusable for ripple-carry words.
module add_bit_core
  import add_bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);

  // Sum and carry from the shared helpers.
  always_comb begin
    s = fa_sum(a, b, ci);
    c = fa_carry(a, b, ci);
  end

endmodule

// File: rtl/add_bit.sv
// add_bit: registered full adder; chain mode feeds back the stored carry for
// LSB-first bit-serial addition.
module add_bit (
  input logic    clk,
  input logic    rst_n,
  add_bit_if.slave bus
);

  logic carry_q;
  logic out_q;
  logic cout_q;
  logic out_valid_q;
  logic ci;
  logic s;
  logic c;

  // Effective carry-in: stored carry in chain mode, external carry otherwise.
  always_comb begin
    ci = bus.chain ? carry_q : bus.cin;
  end

  add_bit_core u_core (
    .a  (bus.a),
    .b  (bus.b),
    .ci (ci),
    .s  (s),
    .c  (c)
  );

  // Result registers; results and stored carry hold while no input is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= 1'b0;
      cout_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      out_q       <= s;
      cout_q      <= c;
      carry_q     <= c;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  // Outputs come straight from registers; no input-to-output path.
  always_comb begin
    bus.out       = out_q;
    bus.cout      = cout_q;
    bus.out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_add_bit.sv
// tb_add_bit: directed table-driven bench for add_bit.
module tb_add_bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  add_bit_if bus ();

  add_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst_n;
    bit in_valid;
    bit a;
    bit b;
    bit cin;
    bit chain;
    bit exp_out;
    bit exp_cout;
    bit exp_valid;
  } vec_t;

  vec_t tt[8];

  // Compare the three outputs against expected values.
  task automatic check(input string name, input bit e_out, input bit e_cout, input bit e_vld);
    checks++;
    if (bus.out !== e_out || bus.cout !== e_cout || bus.out_valid !== e_vld) begin
      errors++;
      $display("FAIL %s: got out=%b cout=%b out_valid=%b, want out=%b cout=%b out_valid=%b",
               name, bus.out, bus.cout, bus.out_valid, e_out, e_cout, e_vld);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and check #1 after the edge.
  task automatic step(input string name, input vec_t v);
    rst_n        = v.rst_n;
    bus.in_valid = v.in_valid;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
    bus.chain    = v.chain;
    @(posedge clk);
    #1;
    check(name, v.exp_out, v.exp_cout, v.exp_valid);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // {rst_n, in_valid, a, b, cin, chain, out, cout, out_valid}
    tt[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
    tt[1] = '{1, 1, 0, 0, 1, 0, 1, 0, 1};
    tt[2] = '{1, 1, 0, 1, 0, 0, 1, 0, 1};
    tt[3] = '{1, 1, 0, 1, 1, 0, 0, 1, 1};
    tt[4] = '{1, 1, 1, 0, 0, 0, 1, 0, 1};
    tt[5] = '{1, 1, 1, 0, 1, 0, 0, 1, 1};
    tt[6] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    tt[7] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 1'b0;
    bus.b        = 1'b0;
    bus.cin      = 1'b0;
    bus.chain    = 1'b0;

    // Reset state
    step("reset0", '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    step("reset1", '{0, 0, 0, 0, 0, 0, 0, 0, 0});

    // Truth table
    for (int i = 0; i < 8; i++) begin
      step($sformatf("tt%0d", i), tt[i]);
    end

    // Serial 1011 + 0110 = 10001, LSB first
    step("ser_b0", '{1, 1, 1, 0, 0, 0, 1, 0, 1});
    step("ser_b1", '{1, 1, 1, 1, 0, 1, 0, 1, 1});
    step("ser_b2", '{1, 1, 0, 1, 0, 1, 0, 1, 1});
    step("ser_b3", '{1, 1, 1, 0, 0, 1, 0, 1, 1});

    // Hold with in_valid low, then chain off the held carry
    step("hold_ld", '{1, 1, 1, 1, 0, 0, 0, 1, 1});
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold%0d", i), '{1, 0, 0, 1, 1, 1, 0, 1, 0});
    end
    step("hold_chain", '{1, 1, 0, 0, 0, 1, 1, 0, 1});

    // Reset beats in_valid and clears the stored carry
    step("rst_pre", '{1, 1, 1, 1, 0, 0, 0, 1, 1});
    step("rst_prio", '{0, 1, 1, 1, 1, 0, 0, 0, 0});
    step("rst_after", '{1, 1, 1, 0, 0, 1, 1, 0, 1});

    // Reset mid-chain
    step("mid_ld", '{1, 1, 1, 1, 1, 0, 1, 1, 1});
    step("mid_rst", '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    step("mid_chain", '{1, 1, 0, 0, 0, 1, 0, 0, 1});

    // chain=1 ignores cin (stored carry 0)
    step("ign_cin", '{1, 1, 0, 0, 1, 1, 0, 0, 1});
    // chain=1 uses stored carry 1 even with cin=0
    step("use_ld", '{1, 1, 1, 1, 0, 0, 0, 1, 1});
    step("use_carry", '{1, 1, 0, 0, 0, 1, 1, 0, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_bit.md
# add_bit

Single-bit full adder with registered outputs, used as the arithmetic primitive of the ALU datapath. It adds operand bits `a`, `b` and carry-in `cin`, and presents sum `out` and carry-out `cout` one clock later with a valid flag. A chain mode feeds the block's own stored carry back as carry-in, so successive accepted inputs form a bit-serial multi-bit addition, LSB first.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset, synchronous and active-low.
- `in_valid`  input  1  operand bits present this cycle; the block samples them.
- `a`  input  1  operand bit A.
- `b`  input  1  operand bit B.
- `cin`  input  1  external carry-in; ignored when `chain`=1.
- `chain`  input  1  1 = use the internally stored carry instead of `cin`.
- `out`  output  1  registered sum bit.
- `cout`  output  1  registered carry-out bit.
- `out_valid`  output  1  `out`/`cout` hold the result of the previous accepted input.

## Operation
- Effective carry-in: `ci = chain ? carry_q : cin`.
- Combinational core: `s = a ^ b ^ ci`; `c = (a & b) | (a & ci) | (b & ci)`.
- On a rising edge with `rst_n`=1 and `in_valid`=1: `out <= s`, `cout <= c`, `carry_q <= c`, `out_valid <= 1`.
- On a rising edge with `rst_n`=1 and `in_valid`=0: `out`, `cout` and `carry_q` hold their values; `out_valid <= 0`.
- `carry_q` is internal state and is always equal to `cout`. It is kept as a separate named signal for clarity.
- Bit-serial use:
  - First bit: `chain`=0, with `cin` as the initial carry.
  - Later bits: `chain`=1.
  - The final `cout` is the MSB carry of the multi-bit sum.
- There is no X-propagation masking; inputs are sampled only when `in_valid`=1.

## Timing
- Latency is 1 cycle. The result for an input sampled at edge N is visible after edge N.
- Throughput is one bit per cycle; there is no backpressure and the block has no ready signal.
- Reset is synchronous: on an edge with `rst_n`=0, `out`=0, `cout`=0, `carry_q`=0 and `out_valid`=0. Reset has priority over `in_valid`.
- Reset mid-chain discards the stored carry. A following `chain`=1 input then sees `ci`=0.
- `chain`=1 in the first accepted cycle after reset uses `carry_q`=0.
- `chain`, `a`, `b` and `cin` are don't-care when `in_valid`=0.
- Outputs change only at clock edges. There is no combinational path from any input to any output.

## Structure
- No shared package is needed. The widths are fixed at 1 bit and there are no typedefs.
- One natural sub-module is `add_bit_core`, a purely combinational full adder (`a`, `b`, `ci` -> `s`, `c`). The top level adds the carry mux, the registers and the valid logic.
- `add_bit_core` is reusable for a future ripple-carry word adder.

## Test plan
- Truth table with `chain`=0, `in_valid`=1, one per cycle, (a,b,cin) = 000,001,010,011,100,101,110,111 -> (out,cout) one cycle later = 00,10,10,01,10,01,01,11. `out_valid`=1 throughout.
- Serial add of 1011 + 0110, LSB first:
  - Stimulus: bit0 with `chain`=0, `cin`=0; bits 1-3 with `chain`=1.
  - Required: outputs 1,0,0,0 and final `cout`=1, i.e. the sum 10001 = 17.
- Hold: after a=1, b=1, cin=0, drop `in_valid` for 3 cycles -> `out`=0 and `cout`=1 held, `out_valid`=0. Then a=0, b=0 with `chain`=1 and `in_valid`=1 -> `out`=1, `cout`=0.
- Reset: drive `rst_n`=0 together with `in_valid`=1, a=b=cin=1 -> after the edge `out`=`cout`=`out_valid`=0. Then a=1, b=0 with `chain`=1 -> `out`=1, `cout`=0, because the stored carry was cleared.
- Reset mid-chain: after a carry of 1 has been stored, assert `rst_n`=0 for one cycle. Then a=0, b=0 with `chain`=1 -> `out`=0, `cout`=0.
- `chain`=1 ignores `cin`: with stored carry 0, drive a=0, b=0, cin=1, `chain`=1 -> `out`=0, `cout`=0.
